// File: rtl/mtwister_stream_if.sv
// Seed-load and random-word stream bundle of mtwister_stream.
// master = seed source / word consumer side, slave = generator side.
interface mtwister_stream_if #(
  parameter int unsigned W = 32
);
  logic         seed_valid;
  logic [W-1:0] seed_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         busy;

  modport master (
    output seed_valid, seed_data, out_ready,
    input  out_valid, out_data, busy
  );

  modport slave (
    input  seed_valid, seed_data, out_ready,
    output out_valid, out_data, busy
  );
endinterface

// File: rtl/mtwister_stream.sv
// Parametrised Mersenne-Twister with valid/ready output, runtime reseed and back-pressure.
// Build option MTWISTER_TEMPER_PIPE_EN: register the tempered word (one extra cycle of first-word latency).
module mtwister_stream #(
  parameter int unsigned W            = 32,
  parameter int unsigned N            = 624,
  parameter int unsigned M            = 397,
  parameter int unsigned R            = 31,
  parameter logic [W-1:0] A           = 32'h9908B0DF,
  parameter int unsigned U            = 11,
  parameter logic [W-1:0] D           = 32'hFFFFFFFF,
  parameter int unsigned S            = 7,
  parameter logic [W-1:0] B           = 32'h9D2C5680,
  parameter int unsigned T            = 15,
  parameter logic [W-1:0] C           = 32'hEFC60000,
  parameter int unsigned L            = 18,
  parameter logic [W-1:0] F           = 32'd1812433253,
  parameter logic [W-1:0] DEFAULT_SEED = 32'd5489
) (
  input  logic                   clk,
  input  logic                   rst_n,
  mtwister_stream_if.slave       bus
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LOWER = (W'(1) << R) - W'(1);
  localparam logic [W-1:0] UPPER = ~LOWER;

  typedef enum logic [1:0] {INIT, TWIST, EXTR} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_inc, idx_mid;
  logic [W-1:0]  mt [N];
  logic [W-1:0]  prev, x, xa, init_w, twist_w;
  logic          last, adv;

  function automatic logic [W-1:0] temper(input logic [W-1:0] v);
    logic [W-1:0] y;
    y = v ^ ((v >> U) & D);
    y = y ^ ((y << S) & B);
    y = y ^ ((y << T) & C);
    y = y ^ (y >> L);
    return y;
  endfunction

  assign last    = (idx == IW'(N - 1));
  assign idx_inc = last ? '0 : idx + IW'(1);
  assign idx_mid = (int'(idx) + int'(M) >= int'(N)) ? IW'(int'(idx) + int'(M) - int'(N))
                                                    : IW'(int'(idx) + int'(M));

  // Recurrence datapath; TWIST reads words already rewritten this pass, as the reference does.
  always_comb begin
    prev    = mt[idx - IW'(1)];
    init_w  = F * (prev ^ (prev >> (W - 2))) + W'(idx);
    x       = (mt[idx] & UPPER) | (mt[idx_inc] & LOWER);
    xa      = (x >> 1) ^ (x[0] ? A : '0);
    twist_w = mt[idx_mid] ^ xa;
  end

`ifdef MTWISTER_TEMPER_PIPE_EN
  logic         vld_p1;
  logic [W-1:0] data_p1;

  assign adv = (state == EXTR) && (!vld_p1 || bus.out_ready);

  // Stage p1: tempered word register, refilled whenever it is empty or being drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (bus.seed_valid) begin
      vld_p1  <= 1'b0;
    end else if (adv) begin
      vld_p1  <= 1'b1;
      data_p1 <= temper(mt[idx]);
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end
`else
  assign adv = (state == EXTR) && bus.out_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.seed_valid) begin
      state_nxt = INIT;
    end else begin
      case (state)
        INIT:    if (last)        state_nxt = TWIST;
        TWIST:   if (last)        state_nxt = EXTR;
        EXTR:    if (adv && last) state_nxt = TWIST;
        default:                  state_nxt = INIT;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state != EXTR);
`ifdef MTWISTER_TEMPER_PIPE_EN
    bus.out_valid = vld_p1;
    bus.out_data  = data_p1;
`else
    bus.out_valid = (state == EXTR);
    bus.out_data  = (state == EXTR) ? temper(mt[idx]) : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                         idx <= IW'(1);
    else if (bus.seed_valid)                            idx <= IW'(1);
    else if ((state == INIT) || (state == TWIST) || adv) idx <= idx_inc;
  end

  // Single write port: seed load, INIT fill or in-place TWIST.
  always_ff @(posedge clk) begin
    if (!rst_n)                 mt[0]   <= DEFAULT_SEED;
    else if (bus.seed_valid)    mt[0]   <= bus.seed_data;
    else if (state == INIT)     mt[idx] <= init_w;
    else if (state == TWIST)    mt[idx] <= twist_w;
  end

endmodule

// File: tb/tb_mtwister_stream.sv
// Self-checking bench for mtwister_stream against a whole-array MT19937 reference model.
module tb_mtwister_stream;
  localparam int N = 624;
`ifdef MTWISTER_TEMPER_PIPE_EN
  localparam int LAT = 2 * N;
`else
  localparam int LAT = 2 * N - 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mtwister_stream_if #(.W(32)) bus ();
  mtwister_stream dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int xfers = 0;

  int unsigned mm [N];
  int          mi;

  typedef struct {
    bit          use_reset;
    logic [31:0] seed;
    int          n;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void m_seed(input int unsigned s);
    mm[0] = s;
    for (int i = 1; i < N; i++)
      mm[i] = 32'd1812433253 * (mm[i-1] ^ (mm[i-1] >> 30)) + int'(i);
    mi = N;
  endfunction

  function automatic int unsigned m_next();
    int unsigned y;
    if (mi >= N) begin
      for (int k = 0; k < N; k++) begin
        y = (mm[k] & 32'h8000_0000) | (mm[(k + 1) % N] & 32'h7FFF_FFFF);
        mm[k] = mm[(k + 397) % N] ^ (y >> 1) ^ (((y & 32'd1) != 0) ? 32'h9908_B0DF : 32'h0);
      end
      mi = 0;
    end
    y = mm[mi];
    mi++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic restart(input bit use_reset, input logic [31:0] s, input bit rdy);
    int cnt;
    bus.out_ready  = rdy;
    bus.seed_valid = 1'b1;
    bus.seed_data  = s;
    if (use_reset) rst_n = 1'b0;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.seed_valid = 1'b0;
    bus.out_ready  = 1'b0;
    m_seed(use_reset ? 32'd5489 : s);
    xfers = 0;
    check("restart_valid", 32'(bus.out_valid), 32'd0);
    check("restart_busy", 32'(bus.busy), 32'd1);
    if (use_reset) check("reset_data", bus.out_data, 32'd0);
    cnt = 0;
    while (!bus.out_valid && cnt < 3 * N) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, LAT);
    check("busy_extr", 32'(bus.busy), 32'd0);
  endtask

  task automatic pull(input int n, input bit rnd, output logic [31:0] last);
    int          got, low, guard;
    bit          held;
    logic [31:0] hd, e;
    got = 0; low = 0; guard = 0; held = 1'b0; hd = '0; last = '0;
    while (got < n && guard < 2 * n + 4 * N) begin
      if (held) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", bus.out_data, hd);
      end
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid) begin
        if (!rnd && xfers > 0) check("gap", low, ((xfers % N) == 0) ? N : 0);
        if (bus.out_ready) begin
          e = m_next();
          check("word", bus.out_data, e);
          last = bus.out_data;
          got++;
          xfers++;
          low = 0;
        end
        held = !bus.out_ready;
        hd   = bus.out_data;
      end else begin
        held = 1'b0;
        low++;
      end
      @(negedge clk);
      guard++;
    end
    bus.out_ready = 1'b0;
    if (got < n) check("pull_timeout", got, n);
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] s2;
    bus.seed_valid = 1'b0;
    bus.seed_data  = '0;
    bus.out_ready  = 1'b0;

    // reset beats a simultaneous seed_valid (seed 1 would give 1791095845)
    tbl[0] = '{use_reset: 1'b1, seed: 32'd1,    n: 1,     exp: 32'd3499211612};
    tbl[1] = '{use_reset: 1'b0, seed: 32'd5489, n: 2,     exp: 32'd581869302};
    tbl[2] = '{use_reset: 1'b0, seed: 32'd1,    n: 1,     exp: 32'd1791095845};
    tbl[3] = '{use_reset: 1'b1, seed: 32'd77,   n: 10000, exp: 32'd4123659995};

    for (int i = 0; i < 4; i++) begin
      restart(tbl[i].use_reset, tbl[i].seed, 1'b0);
      pull(tbl[i].n, 1'b0, w);
      check($sformatf("vec%0d_last", i), w, tbl[i].exp);
    end

    // reseed mid-stream with out_ready high in the same cycle: no transfer, restart
    restart(1'b1, 32'd0, 1'b0);
    pull(5, 1'b0, w);
    check("pre_reseed_valid", 32'(bus.out_valid), 32'd1);
    restart(1'b0, 32'd1, 1'b1);
    pull(1, 1'b0, w);
    check("reseed_first", w, 32'd1791095845);

    // reseed while twisting, then random back-pressure
    restart(1'b0, $urandom, 1'b0);
    pull(N, 1'b0, w);
    check("twist_valid", 32'(bus.out_valid), 32'd0);
    check("twist_busy", 32'(bus.busy), 32'd1);
    repeat (5) @(negedge clk);
    s2 = $urandom;
    restart(1'b0, s2, 1'b1);
    pull(1500, 1'b1, w);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
